// File: rtl/coord_tap_gen.sv
// Sweeps an N_TAPS x N_TAPS window of saturated tap coordinates around a latched
// centre point, presenting one tap per valid/ready handshake in raster order.
module coord_tap_gen #(
  parameter int N_TAPS = 4
) (
  input  logic       CLK,
  input  logic       RST_ASYNC_N,
  input  logic       START,
  input  logic [7:0] COORD_X_IN,
  input  logic [7:0] COORD_Y_IN,
  input  logic       READY_IN,
  output logic       VALID_OUT,
  output logic [7:0] X_OUT,
  output logic [7:0] Y_OUT,
  output logic       CLIP_OUT,
  output logic       LAST_OUT,
  output logic       BUSY_OUT,
  output logic       DONE_OUT
);

  localparam logic [0:0]        ST_IDLE = 1'b0;
  localparam logic [0:0]        ST_EMIT = 1'b1;
  localparam logic [2:0]        CNT_MAX = 3'(N_TAPS - 1);
  localparam logic signed [9:0] ORG_OFS = 10'(N_TAPS / 2 - 1);

  // Clamp a 10-bit signed value into int8 range; MSB of the result flags a clamp.
  function automatic logic [8:0] sat8(input logic signed [9:0] v);
    logic [8:0] r;
    if (v > 10'sd127) begin
      r = {1'b1, 8'h7F};
    end else if (v < -10'sd128) begin
      r = {1'b1, 8'h80};
    end else begin
      r = {1'b0, v[7:0]};
    end
    return r;
  endfunction

  logic [0:0]        state_r;
  logic [7:0]        cx_r, cy_r;
  logic [2:0]        x_cnt_r, y_cnt_r;
  logic              valid_r, clip_r, last_r, busy_r, done_r;
  logic [7:0]        x_r, y_r;

  logic signed [9:0] ctr_x_s, ctr_y_s, raw_x_s, raw_y_s;
  logic [2:0]        nxt_x_s, nxt_y_s;
  logic [7:0]        sat_x_s, sat_y_s;
  logic              clip_x_s, clip_y_s, nxt_last_s;

  // Next tap: first tap of a new window in IDLE, otherwise the raster successor.
  always_comb begin
    ctr_x_s = 10'sd0;
    ctr_y_s = 10'sd0;
    nxt_x_s = 3'd0;
    nxt_y_s = 3'd0;
    if (state_r == ST_IDLE) begin
      ctr_x_s = {{2{COORD_X_IN[7]}}, COORD_X_IN};
      ctr_y_s = {{2{COORD_Y_IN[7]}}, COORD_Y_IN};
    end else begin
      ctr_x_s = {{2{cx_r[7]}}, cx_r};
      ctr_y_s = {{2{cy_r[7]}}, cy_r};
      if (x_cnt_r == CNT_MAX) begin
        nxt_x_s = 3'd0;
        nxt_y_s = y_cnt_r + 3'd1;
      end else begin
        nxt_x_s = x_cnt_r + 3'd1;
        nxt_y_s = y_cnt_r;
      end
    end
    raw_x_s = ctr_x_s - ORG_OFS + $signed({7'd0, nxt_x_s});
    raw_y_s = ctr_y_s - ORG_OFS + $signed({7'd0, nxt_y_s});
    {clip_x_s, sat_x_s} = sat8(raw_x_s);
    {clip_y_s, sat_y_s} = sat8(raw_y_s);
    nxt_last_s = (nxt_x_s == CNT_MAX) && (nxt_y_s == CNT_MAX);
  end

  // Sweep FSM with fully registered outputs; X/Y keep their last tap in IDLE.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_r <= ST_IDLE;
      cx_r    <= 8'd0;
      cy_r    <= 8'd0;
      x_cnt_r <= 3'd0;
      y_cnt_r <= 3'd0;
      valid_r <= 1'b0;
      x_r     <= 8'd0;
      y_r     <= 8'd0;
      clip_r  <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            state_r <= ST_EMIT;
            cx_r    <= COORD_X_IN;
            cy_r    <= COORD_Y_IN;
            x_cnt_r <= 3'd0;
            y_cnt_r <= 3'd0;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            x_r     <= sat_x_s;
            y_r     <= sat_y_s;
            clip_r  <= clip_x_s | clip_y_s;
            last_r  <= nxt_last_s;
          end
        end
        ST_EMIT: begin
          if (READY_IN) begin
            if (last_r) begin
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              clip_r  <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              x_cnt_r <= nxt_x_s;
              y_cnt_r <= nxt_y_s;
              x_r     <= sat_x_s;
              y_r     <= sat_y_s;
              clip_r  <= clip_x_s | clip_y_s;
              last_r  <= nxt_last_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          clip_r  <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign VALID_OUT = valid_r;
  assign X_OUT     = x_r;
  assign Y_OUT     = y_r;
  assign CLIP_OUT  = clip_r;
  assign LAST_OUT  = last_r;
  assign BUSY_OUT  = busy_r;
  assign DONE_OUT  = done_r;

endmodule
